fifo_stream_reader: RTL



---
 rtl/fifo_stream_reader.sv | 65 ++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO (1-cycle read latency) into a valid/ready stream through a 2-entry skid buffer.
// Optional beat counter o_xfer_cnt is built when FIFO_RD_CNT_EN is defined.
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 8
`ifdef FIFO_RD_CNT_EN
   , parameter int CNT_WIDTH = 16
`endif
) (
   input  logic                  i_sys_clk,
   input  logic                  i_sys_rst,
   input  logic                  i_fifo_empty,
   input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
   output logic                  o_fifo_rden,
   output logic                  o_m_valid,
   output logic [DATA_WIDTH-1:0] o_m_data,
   input  logic                  i_m_ready
`ifdef FIFO_RD_CNT_EN
   , output logic [CNT_WIDTH-1:0] o_xfer_cnt
`endif
);

   logic [DATA_WIDTH-1:0] mem [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic                  inflight;
   logic [1:0]            occ;
   logic                  pop;
   logic [2:0]            level;

   assign o_m_valid = (occ != 2'd0);
   assign o_m_data  = mem[rd_ptr];

   // level is the occupancy after this cycle; a read is only issued if its word will have a slot.
   always_comb begin
      pop         = o_m_valid & i_m_ready;
      level       = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
      o_fifo_rden = ~i_sys_rst & ~i_fifo_empty & (level < 3'd2);
   end

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         for (int i = 0; i < 2; i++) mem[i] <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         inflight <= 1'b0;
         occ      <= 2'd0;
      end else begin
         inflight <= o_fifo_rden;
         if (inflight) begin
            mem[wr_ptr] <= i_fifo_rdata;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         occ <= level[1:0];
      end
   end

`ifdef FIFO_RD_CNT_EN
   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) o_xfer_cnt <= '0;
      else if (pop)  o_xfer_cnt <= o_xfer_cnt + 1'b1;
   end
`endif

endmodule
